// File: rtl/csr_pkg.sv
// csr_pkg: shared constants and types for the machine-mode trap controller.
//   - CSR addresses (mstatus/mtvec/mepc/mcause)
//   - mcause value written on external-interrupt trap entry
//   - MIE/MPIE bit positions inside mstatus
//   - PC-source select encodings (0..5; 4 = MTVEC, 5 = MEPC)
//   - trap FSM state enum
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // Machine external interrupt cause (interrupt bit set, code 11).
    localparam logic [31:0] MCAUSE_MEXT = 32'h8000_000B;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;

    // Word alignment mask for mtvec/mepc (low two bits always read 0).
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    localparam logic [2:0] PC_SEL_NEXT  = 3'd0;
    localparam logic [2:0] PC_SEL_JALR  = 3'd1;
    localparam logic [2:0] PC_SEL_BRN   = 3'd2;
    localparam logic [2:0] PC_SEL_JAL   = 3'd3;
    localparam logic [2:0] PC_SEL_MTVEC = 3'd4;
    localparam logic [2:0] PC_SEL_MEPC  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRAP = 2'd1,
        ST_RET  = 2'd2
    } trap_state_e;

endpackage

// File: rtl/intr_csr_ctrl_if.sv
// intr_csr_ctrl_if: bundle between the control unit / CSR datapath (master)
// and the trap controller (slave).
//   master drives : INTR, INSTR_DONE, MRET, PC, PC_SEL_IN, CSR_WE, CSR_ADDR, CSR_WD
//   slave drives  : CSR_RD, PC_SEL, MTVEC, MEPC, INT_ACK, STATE (FSM debug view)
//
// Signalling: there is no valid/ready pair here. INSTR_DONE is a one-cycle
// strobe marking an instruction boundary; MRET is only meaningful in a cycle
// where INSTR_DONE is high. CSR_WE is a single-cycle write command that is
// always accepted (no back-pressure). INT_ACK and the PC_SEL override last
// exactly one cycle.
interface intr_csr_ctrl_if;
    import csr_pkg::*;

    logic        INTR;
    logic        INSTR_DONE;
    logic        MRET;
    logic [31:0] PC;
    logic [2:0]  PC_SEL_IN;
    logic        CSR_WE;
    logic [11:0] CSR_ADDR;
    logic [31:0] CSR_WD;
    logic [31:0] CSR_RD;
    logic [2:0]  PC_SEL;
    logic [31:0] MTVEC;
    logic [31:0] MEPC;
    logic        INT_ACK;
    trap_state_e STATE;

    modport master (
        output INTR, INSTR_DONE, MRET, PC, PC_SEL_IN, CSR_WE, CSR_ADDR, CSR_WD,
        input  CSR_RD, PC_SEL, MTVEC, MEPC, INT_ACK, STATE
    );

    modport slave (
        input  INTR, INSTR_DONE, MRET, PC, PC_SEL_IN, CSR_WE, CSR_ADDR, CSR_WD,
        output CSR_RD, PC_SEL, MTVEC, MEPC, INT_ACK, STATE
    );

endinterface

// File: rtl/intr_edge.sv
// intr_edge: registers the external interrupt level and produces a one-cycle
// pulse on its rising edge.
// Configuration macro: INTR_SYNC_EN -- when defined, INTR first passes through
// a two-flop synchronizer (adds two cycles of latency).
// Ports:
//   clk_i   core clock
//   rst_i   asynchronous active-high reset
//   intr_i  raw interrupt level
//   pulse_o one-cycle rising-edge pulse
module intr_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic intr_i,
    output logic pulse_o
);

    logic intr_src;
    logic intr_q;
    logic intr_prev_q;

`ifdef INTR_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= intr_i;
            sync2_q <= sync1_q;
        end
    end

    assign intr_src = sync2_q;
`else
    assign intr_src = intr_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            intr_q      <= 1'b0;
            intr_prev_q <= 1'b0;
        end else begin
            intr_q      <= intr_src;
            intr_prev_q <= intr_q;
        end
    end

    assign pulse_o = intr_q & ~intr_prev_q;

endmodule

// File: rtl/intr_csr_ctrl.sv
// intr_csr_ctrl: machine-mode trap controller. Owns mstatus (MIE/MPIE), mtvec,
// mepc and mcause, latches the external interrupt as "pending", and overrides
// the PC-source select for one cycle on trap entry (MTVEC) or mret (MEPC).
// Configuration macro: INTR_SYNC_EN (see intr_edge).
// Parameters:
//   RESET_MTVEC  mtvec value after reset
// Ports:
//   CLK, RST     core clock, asynchronous active-high reset
//   bus (slave)  control/CSR/PC-mux signals, see intr_csr_ctrl_if
module intr_csr_ctrl
    import csr_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic           CLK,
    input  logic           RST,
    intr_csr_ctrl_if.slave bus
);

    trap_state_e state_q, state_d;
    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic        pend_q, pend_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic        intr_pulse;
    logic [2:0]  pc_sel;
    logic        int_ack;
    logic [31:0] csr_rd;

    intr_edge u_intr_edge (
        .clk_i   (CLK),
        .rst_i   (RST),
        .intr_i  (bus.INTR),
        .pulse_o (intr_pulse)
    );

    // FSM: state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state. TRAP and RET last one cycle; an enabled pending
    // interrupt beats mret at the same boundary.
    always_comb begin
        state_d = ST_IDLE;
        if (state_q == ST_IDLE && bus.INSTR_DONE) begin
            if (pend_q && mie_q) state_d = ST_TRAP;
            else if (bus.MRET)   state_d = ST_RET;
        end
    end

    // FSM: outputs
    always_comb begin
        pc_sel  = bus.PC_SEL_IN;
        int_ack = 1'b0;
        case (state_q)
            ST_TRAP: begin
                pc_sel  = PC_SEL_MTVEC;
                int_ack = 1'b1;
            end
            ST_RET:  pc_sel = PC_SEL_MEPC;
            default: ;
        endcase
    end

    // CSR next state. Software writes are applied first so the FSM's trap/
    // return side effects override them for mstatus and mepc.
    always_comb begin
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;

        if (bus.CSR_WE) begin
            case (bus.CSR_ADDR)
                CSR_MSTATUS: begin
                    mie_d  = bus.CSR_WD[MIE_BIT];
                    mpie_d = bus.CSR_WD[MPIE_BIT];
                end
                CSR_MTVEC: mtvec_d = bus.CSR_WD & ALIGN_MASK;
                CSR_MEPC:  mepc_d  = bus.CSR_WD & ALIGN_MASK;
                default: ;
            endcase
        end

        if (state_q == ST_TRAP) begin
            mepc_d   = bus.PC & ALIGN_MASK;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
            mcause_d = MCAUSE_MEXT;
        end else if (state_q == ST_RET) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end

        // A new edge in the trap cycle must not be lost.
        pend_d = (pend_q && state_q != ST_TRAP) || intr_pulse;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            pend_q   <= 1'b0;
            mtvec_q  <= RESET_MTVEC & ALIGN_MASK;
            mepc_q   <= 32'h0;
            mcause_q <= 32'h0;
        end else begin
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            pend_q   <= pend_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
    end

    always_comb begin
        csr_rd = 32'h0;
        case (bus.CSR_ADDR)
            CSR_MSTATUS: begin
                csr_rd[MIE_BIT]  = mie_q;
                csr_rd[MPIE_BIT] = mpie_q;
            end
            CSR_MTVEC:  csr_rd = mtvec_q;
            CSR_MEPC:   csr_rd = mepc_q;
            CSR_MCAUSE: csr_rd = mcause_q;
            default: ;
        endcase
    end

    assign bus.CSR_RD  = csr_rd;
    assign bus.PC_SEL  = pc_sel;
    assign bus.INT_ACK = int_ack;
    assign bus.MTVEC   = mtvec_q;
    assign bus.MEPC    = mepc_q;
    assign bus.STATE   = state_q;

endmodule

// File: tb/tb_intr_csr_ctrl.sv
// tb_intr_csr_ctrl: directed test-plan steps followed by a randomized phase,
// all checked every cycle against a behavioural model of the trap rules.
module tb_intr_csr_ctrl;

    localparam logic [31:0] RST_VEC = 32'h0000_1000;
`ifdef INTR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic CLK = 1'b0;
    logic RST;

    intr_csr_ctrl_if bus ();

    intr_csr_ctrl #(.RESET_MTVEC(RST_VEC)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Model: mode 0 = normal, 1 = trap-entry cycle, 2 = return cycle.
    int          m_mode;
    bit          m_mie, m_mpie, m_pend;
    logic [31:0] m_mtvec, m_mepc, m_mcause;
    bit          hist[0:3];   // past INTR samples, hist[0] most recent

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (a == 12'h300)      r = (32'(m_mie) << 3) | (32'(m_mpie) << 7);
        else if (a == 12'h305) r = m_mtvec;
        else if (a == 12'h341) r = m_mepc;
        else if (a == 12'h342) r = m_mcause;
        return r;
    endfunction

    task automatic model_reset();
        m_mode   = 0;
        m_mie    = 0;
        m_mpie   = 0;
        m_pend   = 0;
        m_mtvec  = RST_VEC;
        m_mepc   = 32'h0;
        m_mcause = 32'h0;
        for (int i = 0; i < 4; i++) hist[i] = 0;
    endtask

    task automatic check_outputs();
        logic [2:0] exp_sel;
        exp_sel = (m_mode == 1) ? 3'd4 : (m_mode == 2) ? 3'd5 : bus.PC_SEL_IN;
        check("pc_sel", 32'(bus.PC_SEL), 32'(exp_sel));
        check("int_ack", 32'(bus.INT_ACK), 32'(m_mode == 1));
        check("mtvec_out", bus.MTVEC, m_mtvec);
        check("mepc_out", bus.MEPC, m_mepc);
        check("csr_rd", bus.CSR_RD, m_read(bus.CSR_ADDR));
    endtask

    // Advance one clock: predict from current inputs, then compare.
    task automatic tick();
        int          n_mode;
        bit          n_mie, n_mpie, n_pend, edge_seen;
        logic [31:0] n_mtvec, n_mepc, n_mcause;
        edge_seen = hist[LAT] && !hist[LAT+1];
        n_mode = 0;
        n_mie = m_mie; n_mpie = m_mpie;
        n_mtvec = m_mtvec; n_mepc = m_mepc; n_mcause = m_mcause;
        if (m_mode == 0 && bus.INSTR_DONE) begin
            if (m_pend && m_mie) n_mode = 1;
            else if (bus.MRET)   n_mode = 2;
        end
        if (bus.CSR_WE) begin
            if (bus.CSR_ADDR == 12'h300 && m_mode == 0) begin
                n_mie  = bus.CSR_WD[3];
                n_mpie = bus.CSR_WD[7];
            end
            if (bus.CSR_ADDR == 12'h305) n_mtvec = {bus.CSR_WD[31:2], 2'b00};
            if (bus.CSR_ADDR == 12'h341 && m_mode != 1) n_mepc = {bus.CSR_WD[31:2], 2'b00};
        end
        if (m_mode == 1) begin
            n_mepc   = {bus.PC[31:2], 2'b00};
            n_mpie   = m_mie;
            n_mie    = 0;
            n_mcause = 32'h8000_000B;
        end else if (m_mode == 2) begin
            n_mie  = m_mpie;
            n_mpie = 1;
        end
        n_pend = (m_pend && m_mode != 1) || edge_seen;
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = bus.INTR;
        @(posedge CLK);
        #1;
        m_mode = n_mode; m_mie = n_mie; m_mpie = n_mpie; m_pend = n_pend;
        m_mtvec = n_mtvec; m_mepc = n_mepc; m_mcause = n_mcause;
        check_outputs();
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.CSR_WE = 1'b1; bus.CSR_ADDR = a; bus.CSR_WD = d;
        tick();
        bus.CSR_WE = 1'b0;
    endtask

    // At most four calls between ticks so sampling stays clear of edges.
    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        bus.CSR_ADDR = a;
        #1;
        check(tag, bus.CSR_RD, exp);
    endtask

    task automatic arm_intr();
        bus.INTR = 1'b0; tick();
        bus.INTR = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.INTR = 0; bus.INSTR_DONE = 0; bus.MRET = 0; bus.PC = 32'h0;
        bus.PC_SEL_IN = 3'd2; bus.CSR_WE = 0; bus.CSR_ADDR = 12'h300; bus.CSR_WD = 32'h0;
        RST = 1'b1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Reset values
        check("rst_pc_sel", 32'(bus.PC_SEL), 32'd2);
        check("rst_int_ack", 32'(bus.INT_ACK), 32'd0);
        rd("rst_mstatus", 12'h300, 32'h0);
        rd("rst_mtvec", 12'h305, RST_VEC);
        rd("rst_mepc", 12'h341, 32'h0);
        rd("rst_mcause", 12'h342, 32'h0);
        tick();

        // Basic trap entry
        wr(12'h305, 32'h0000_0103);
        wr(12'h300, 32'h0000_0008);
        rd("mtvec_align", 12'h305, 32'h100);
        rd("mie_set", 12'h300, 32'h8);
        bus.PC = 32'h40;
        arm_intr();
        bus.INSTR_DONE = 1; tick();
        check("trap_pc_sel", 32'(bus.PC_SEL), 32'd4);
        check("trap_ack", 32'(bus.INT_ACK), 32'd1);
        bus.INSTR_DONE = 0; tick();
        check("trap_one_cycle", 32'(bus.INT_ACK), 32'd0);
        rd("trap_mepc", 12'h341, 32'h40);
        rd("trap_mstatus", 12'h300, 32'h80);
        rd("trap_mcause", 12'h342, 32'h8000_000B);

        // Interrupt inside handler, then mret, then trap again
        arm_intr();
        bus.INSTR_DONE = 1; bus.MRET = 1; tick();
        check("ret_pc_sel", 32'(bus.PC_SEL), 32'd5);
        bus.INSTR_DONE = 0; bus.MRET = 0; tick();
        rd("ret_mstatus", 12'h300, 32'h88);
        bus.INSTR_DONE = 1; tick();
        check("retrap_pc_sel", 32'(bus.PC_SEL), 32'd4);
        bus.INSTR_DONE = 0; tick();

        // Pending held while MIE=0, taken once MIE is set
        arm_intr();
        for (int i = 0; i < 6; i++) begin
            bus.INSTR_DONE = 1; tick();
            check("masked_no_ack", 32'(bus.INT_ACK), 32'd0);
            bus.INSTR_DONE = 0; tick();
        end
        wr(12'h300, 32'h0000_0008);
        bus.INSTR_DONE = 1; tick();
        check("unmask_trap", 32'(bus.PC_SEL), 32'd4);
        bus.INSTR_DONE = 0; tick();

        // CSR mepc write colliding with trap cycle
        wr(12'h300, 32'h0000_0008);
        arm_intr();
        bus.PC = 32'h80;
        bus.INSTR_DONE = 1; tick();
        bus.INSTR_DONE = 0;
        wr(12'h341, 32'h0000_0200);
        check("mepc_collide", bus.MEPC, 32'h80);

        // Reset during the trap cycle
        wr(12'h300, 32'h0000_0008);
        arm_intr();
        bus.INTR = 0;
        bus.INSTR_DONE = 1; tick();
        bus.INSTR_DONE = 0;
        bus.PC_SEL_IN = 3'd3;
        #1 RST = 1'b1;
        #1;
        check("rst_mid_pc_sel", 32'(bus.PC_SEL), 32'd3);
        check("rst_mid_ack", 32'(bus.INT_ACK), 32'd0);
        model_reset();
        @(posedge CLK);
        #1 RST = 1'b0;
        rd("rst2_mstatus", 12'h300, 32'h0);
        rd("rst2_mtvec", 12'h305, RST_VEC);
        rd("rst2_mepc", 12'h341, 32'h0);
        rd("rst2_mcause", 12'h342, 32'h0);
        check_outputs();

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            logic [11:0] addrs [5];
            addrs = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h7C0};
            if ($urandom_range(0, 3) == 0) bus.INTR = ~bus.INTR;
            bus.INSTR_DONE = ($urandom_range(0, 2) == 0);
            bus.MRET       = ($urandom_range(0, 1) == 0);
            bus.PC         = $urandom;
            bus.PC_SEL_IN  = 3'($urandom_range(0, 3));
            bus.CSR_WE     = ($urandom_range(0, 3) == 0);
            bus.CSR_ADDR   = addrs[$urandom_range(0, 4)];
            bus.CSR_WD     = ($urandom_range(0, 1) == 0) ? 32'h0000_0008 : $urandom;
            tick();
        end
        bus.CSR_WE = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
